// File: rtl/fetch_redirect_unit_pkg.sv
// antares_pkg: shared constants, IF/ID register layout and PC alignment helper
// for the Antares-R2 fetch stage.
package antares_pkg;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } ifid_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: ID-side controls, instruction memory port and IF/ID outputs
// of the fetch stage; slave is the fetch unit, master is its environment.
interface fetch_redirect_unit_if #(parameter int CNT_W = 16);
   logic             stall;
   logic             selPC;
   logic [31:0]      branch_target;
   logic             jump;
   logic [31:0]      jump_target;
   logic [31:0]      imem_data;
   logic [31:0]      imem_addr;
   logic [31:0]      ifid_instr;
   logic [31:0]      ifid_pc4;
   logic             ifid_valid;
   logic [CNT_W-1:0] redirect_count;
   logic             misaligned;

   modport slave (
      input  stall, selPC, branch_target, jump, jump_target, imem_data,
      output imem_addr, ifid_instr, ifid_pc4, ifid_valid, redirect_count, misaligned
   );

   modport master (
      output stall, selPC, branch_target, jump, jump_target, imem_data,
      input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, redirect_count, misaligned
   );
endinterface

// File: rtl/fetch_redirect_unit_ifid_reg.sv
// fetch_ifid_reg: IF/ID pipeline register; hold freezes it, flush loads a bubble
// (hold takes priority so a stalled redirect never squashes).
module fetch_ifid_reg
   import antares_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hold_i,
   input  logic        flush_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc4_i,
   output ifid_t       ifid_o
);
   localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

   ifid_t ifid_q, ifid_d;

   always_comb
      ifid_d = hold_i  ? ifid_q :
               flush_i ? BUBBLE :
                         '{instr: instr_i, pc4: pc4_i, valid: 1'b1};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ifid_q <= BUBBLE;
      else        ifid_q <= ifid_d;

   assign ifid_o = ifid_q;
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: PC owner and IF stage; redirects on ID-resolved branch/jump
// with a one-bubble penalty, honours stalls, counts redirects, flags misaligned targets.
module fetch_redirect_unit
   import antares_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   fetch_redirect_unit_if.slave bus
);
   logic [31:0]      pc_q, pc_d, pc4, tgt;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mis_q, mis_d;
   logic             redir;
   ifid_t            ifid;

   // a bubble in IF/ID masks ID's select lines, so redirects can never chain
   assign redir = ifid.valid & ~bus.stall & (bus.selPC | bus.jump);
   assign tgt   = bus.selPC ? bus.branch_target : bus.jump_target;
   assign pc4   = pc_q + PC_STEP;

   always_comb begin
      pc_d  = bus.stall ? pc_q : redir ? word_align(tgt) : pc4;
      cnt_d = (redir && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
      mis_d = mis_q | (redir & |tgt[1:0]);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         cnt_q <= '0;
         mis_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         mis_q <= mis_d;
      end

   fetch_ifid_reg u_ifid (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold_i  (bus.stall),
      .flush_i (redir),
      .instr_i (bus.imem_data),
      .pc4_i   (pc4),
      .ifid_o  (ifid)
   );

   assign bus.imem_addr      = pc_q;
   assign bus.ifid_instr     = ifid.instr;
   assign bus.ifid_pc4       = ifid.pc4;
   assign bus.ifid_valid     = ifid.valid;
   assign bus.redirect_count = cnt_q;
   assign bus.misaligned     = mis_q;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed fetch/redirect scenarios checked every cycle
// against a behavioural pipeline model, plus hand-computed literal checkpoints.
module tb_fetch_redirect_unit;
   localparam int          CNT_W = 4;
   localparam logic [31:0] RPC   = 32'h0000_0040;
   localparam int          CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   fetch_redirect_unit_if #(.CNT_W(CNT_W)) b ();

   fetch_redirect_unit #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b.slave)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign b.imem_data = mem(b.imem_addr);

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
      end
   endtask

   // model: what each fetch-stage register must hold, from the pipeline rules
   logic [31:0] m_pc = RPC, m_instr = 32'h0, m_pc4 = 32'h0;
   logic        m_valid = 1'b0, m_mis = 1'b0;
   int          m_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      logic [31:0] t;
      if (!rst_n) begin
         m_pc = RPC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_mis = 0;
      end else if (b.stall) begin
      end else if (m_valid && (b.selPC || b.jump)) begin
         t = b.selPC ? b.branch_target : b.jump_target;
         m_pc = t - (t % 4);
         m_instr = 0; m_pc4 = 0; m_valid = 0;
         m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
         if (t % 4 != 0) m_mis = 1;
      end else begin
         m_instr = mem(m_pc);
         m_pc = m_pc + 4;
         m_pc4 = m_pc;
         m_valid = 1;
      end
   end

   always @(negedge clk) begin
      chk("cmp_imem_addr", b.imem_addr, m_pc);
      chk("cmp_ifid_instr", b.ifid_instr, m_instr);
      chk("cmp_ifid_pc4", b.ifid_pc4, m_pc4);
      chk("cmp_ifid_valid", 32'(b.ifid_valid), 32'(m_valid));
      chk("cmp_redirect_count", 32'(b.redirect_count), 32'(m_cnt));
      chk("cmp_misaligned", 32'(b.misaligned), 32'(m_mis));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      b.stall = 0; b.selPC = 0; b.jump = 0; b.branch_target = 0; b.jump_target = 0;
      #1 rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_addr", b.imem_addr, 32'h40);
      chk("rst_valid", 32'(b.ifid_valid), 0);
      chk("rst_cnt", 32'(b.redirect_count), 0);
      rst_n = 1'b1;
      tick();
      chk("seq_addr44", b.imem_addr, 32'h44);
      chk("seq_valid", 32'(b.ifid_valid), 1);
      chk("seq_pc4", b.ifid_pc4, 32'h44);
      chk("seq_instr", b.ifid_instr, mem(32'h40));
      tick();
      chk("seq_addr48", b.imem_addr, 32'h48);
      b.selPC = 1; b.branch_target = 32'h100;
      tick();
      chk("br_addr", b.imem_addr, 32'h100);
      chk("br_bubble", 32'(b.ifid_valid), 0);
      chk("br_cnt", 32'(b.redirect_count), 1);
      tick();
      chk("br_bubble_ignore", b.imem_addr, 32'h104);
      chk("br_tgt_instr", b.ifid_instr, mem(32'h100));
      b.selPC = 0;
      b.stall = 1; b.selPC = 1; b.branch_target = 32'h200;
      repeat (3) tick();
      chk("stall_addr", b.imem_addr, 32'h104);
      chk("stall_pc4", b.ifid_pc4, 32'h104);
      chk("stall_cnt", 32'(b.redirect_count), 1);
      b.stall = 0;
      tick();
      chk("post_stall_redir", b.imem_addr, 32'h200);
      chk("post_stall_cnt", 32'(b.redirect_count), 2);
      b.selPC = 0;
      tick();
      b.selPC = 1; b.jump = 1; b.branch_target = 32'h200; b.jump_target = 32'h300;
      tick();
      chk("both_sel_wins", b.imem_addr, 32'h200);
      b.selPC = 0; b.jump = 0;
      tick();
      b.jump = 1; b.jump_target = 32'h102;
      tick();
      chk("mis_addr", b.imem_addr, 32'h100);
      chk("mis_flag", 32'(b.misaligned), 1);
      b.jump = 0;
      tick();
      b.selPC = 1; b.branch_target = 32'hFFFF_FFFC;
      tick();
      chk("wrap_top", b.imem_addr, 32'hFFFF_FFFC);
      chk("mis_sticky", 32'(b.misaligned), 1);
      b.selPC = 0;
      tick();
      chk("wrap_zero", b.imem_addr, 32'h0);
      chk("wrap_pc4", b.ifid_pc4, 32'h0);
      tick();
      for (int i = 0; i < 12; i++) begin
         b.selPC = 1; b.branch_target = 32'h1000 + 32'(i * 16);
         tick();
         b.selPC = 0;
         tick();
      end
      chk("sat_cnt", 32'(b.redirect_count), 32'hF);
      b.selPC = 1; b.branch_target = 32'h500;
      rst_n = 1'b0;
      #1;
      chk("async_rst_addr", b.imem_addr, 32'h40);
      chk("async_rst_cnt", 32'(b.redirect_count), 0);
      chk("async_rst_mis", 32'(b.misaligned), 0);
      b.selPC = 0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("refetch_addr", b.imem_addr, 32'h44);
      chk("refetch_instr", b.ifid_instr, mem(32'h40));
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Instruction-fetch stage of the Antares-R2 pipeline: owns the program counter, drives the instruction-memory address, and fills the IF/ID pipeline register. It is the consumer of the ID-stage branch comparator's `selPC` and of the jump decode. On a taken branch or jump it redirects the PC and squashes the wrong-path instruction, so branches resolved in ID cost exactly one bubble. It also honours hazard-unit stalls and counts redirects for performance measurement.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, 16: width of the redirect counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hazard-unit stall; freezes the PC and IF/ID.
- `selPC`  in  1  taken-branch select from the ID-stage branch comparator.
- `branch_target`  in  32  ID-computed branch target.
- `jump`  in  1  ID instruction is J/JAL.
- `jump_target`  in  32  ID-computed jump target.
- `imem_data`  in  32  instruction word at `imem_addr` (combinational read).
- `imem_addr`  out  32  current PC.
- `ifid_instr`  out  32  registered instruction to ID.
- `ifid_pc4`  out  32  registered PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `redirect_count`  out  CNT_W  number of redirects taken, saturating.
- `misaligned`  out  1  sticky flag: a redirect target had bits [1:0] != 0.

## Operation
- Registered state: `pc`, IF/ID (`instr`, `pc4`, `valid`), `redirect_count`, `misaligned`. `imem_addr` = `pc`.
- **Redirect condition:** `redir = ifid_valid & ~stall & (selPC | jump)`.
  - `selPC` and `jump` from a bubble (`ifid_valid = 0`) are ignored.
- **Per-edge action, in priority order:**
  1. **Stall** (`stall = 1`): all registers hold. `selPC` and `jump` are ignored; ID re-evaluates next cycle.
  2. **Redirect:**
     - `pc <= {tgt[31:2], 2'b00}`, where `tgt = selPC ? branch_target : jump_target`. `selPC` wins if both are asserted.
     - `ifid_instr <= 32'h0000_0000` (NOP), `ifid_valid <= 0`, `ifid_pc4 <= 0`.
     - `redirect_count` increments, saturating at all ones.
     - If `tgt[1:0] != 0`, set `misaligned <= 1`.
  3. **Sequential:** `pc <= pc + 4` (mod 2^32, so 32'hFFFF_FFFC wraps to 0). `ifid_instr <= imem_data`, `ifid_pc4 <= pc + 4`, `ifid_valid <= 1`.
- `misaligned` clears only on reset.

## Timing
- Asserting `rst_n = 0` asynchronously forces:
  - `pc` and `imem_addr` = `RESET_PC`;
  - `ifid_instr` = 0, `ifid_pc4` = 0, `ifid_valid` = 0;
  - `redirect_count` = 0, `misaligned` = 0.
- Reset asserted mid-operation discards any in-flight redirect. First fetch after deassertion is from `RESET_PC`.
- Fetch latency: the word at `pc` appears on `ifid_instr` one edge after `pc` is presented.
- Branch penalty: one cycle.
  - Edge N captures the redirect.
  - Cycle N+1: `imem_addr` = target, and ID sees the bubble.
  - Edge N+1 captures the target instruction.
- `stall` and `redir` in the same cycle: the stall wins and no redirect occurs.
- Back-to-back redirects are impossible, because the bubble after a redirect masks any `selPC`/`jump` in the following cycle.

## Structure
- Shared package `antares_pkg`: `NOP_INSTR` (32'h0), `PC_STEP` (4), `DEFAULT_RESET_PC`.
- One sub-module, `fetch_ifid_reg`: the IF/ID register with hold (stall) and squash (flush) controls.
- PC next-state mux, redirect logic, counter and flag live in the top module.

## Test plan
- Reset with `RESET_PC` = 32'h0000_0040, then release with no stall: `imem_addr` steps 0x40, 0x44, 0x48; `ifid_valid` rises one edge after release; `ifid_pc4` = 0x44 with the word fetched at 0x40.
- `selPC = 1`, `branch_target` = 0x100 while `ifid_valid = 1`: next `imem_addr` = 0x100; `ifid_valid = 0` for exactly one cycle; `redirect_count` = 1; the word at 0x100 is captured the following edge.
- `stall = 1` for 3 cycles together with `selPC = 1`: PC and IF/ID frozen, `redirect_count` unchanged; after the stall drops with `selPC = 1`, the redirect happens.
- `selPC = 1` and `jump = 1` together (branch 0x200, jump 0x300): PC becomes 0x200. `selPC = 1` while `ifid_valid = 0`: ignored, PC keeps incrementing.
- `jump_target` = 0x0000_0102: PC becomes 0x100, `misaligned = 1` and stays set through later redirects until `rst_n` pulses low.
- Boundaries: PC at 0xFFFF_FFFC with no redirect wraps to 0x0. With `CNT_W = 4`, 17 redirects leave `redirect_count` at 4'hF.
